writeback: RTL and testbench
============================

// Module: writeback
// PURPOSE
//  Write-side counterpart to the decode-stage register read ports: retires results into the 32x32 register file.
//  Accepts ALU results immediately and load results after a variable-latency memory response.
//  Produces one registered write per retired instruction and never writes r0.
//  Sits after execute/memory; its rf_* outputs drive the register file write port.
// PARAMETERS
//  XLEN   32  data width of results and register file entries
//  RA_W   5   register address width (32 registers)
//  CNT_W  32  width of retired-instruction counter instret_o
// PORTS
//  clk          input   1      clock; all state on rising edge
//  reset        input   1      asynchronous, active-low reset
//  ex_valid_i   input   1      execute presents a result/request this cycle
//  ex_ready_o   output  1      writeback can accept (combinational from state)
//  ex_rd_i      input   RA_W   destination register
//  ex_data_i    input   XLEN   ALU result (non-load)
//  ex_is_load_i input   1      1 = result comes from memory
//  ex_funct3_i  input   3      load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  ex_addr_i    input   2      load byte offset (addr[1:0])
//  mem_rvalid_i input   1      memory read data valid (single-cycle pulse)
//  mem_rdata_i  input   XLEN   aligned memory word
//  rf_we_o      output  1      register file write enable (one-cycle pulse)
//  rf_rd_o      output  RA_W   register file write address
//  rf_wdata_o   output  XLEN   register file write data
//  busy_o       output  1      load outstanding (state WAIT_LOAD)
//  err_o        output  1      sticky: mem_rvalid_i seen while IDLE
//  instret_o    output  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; rf_we_o=0, rf_rd_o=0, rf_wdata_o=0, busy_o=0, err_o=0, instret_o=0; pending load discarded.
//  FSM states IDLE, WAIT_LOAD. ex_ready_o = (state==IDLE). Accept = ex_valid_i & ex_ready_o.
//  IDLE, accept, !ex_is_load_i: next cycle rf_we_o=(ex_rd_i!=0), rf_rd_o=ex_rd_i, rf_wdata_o=ex_data_i; stay IDLE.
//  IDLE, accept, ex_is_load_i: latch rd, funct3, offset; -> WAIT_LOAD; no write.
//  WAIT_LOAD: ex_ready_o=0; wait any number of cycles for mem_rvalid_i.
//  WAIT_LOAD & mem_rvalid_i: next cycle write extracted data to latched rd (suppressed if rd==0); -> IDLE.
//   Earliest next accept is the cycle after mem_rvalid_i.
//  Extraction: LB/LBU byte = rdata[8*off+:8]; LH/LHU half = rdata[16*off[1]+:16] (off[0] ignored); LW whole word.
//   LB/LH sign-extend to XLEN; LBU/LHU zero-extend; other funct3 values treated as LW.
//  rf_we_o high exactly one cycle per non-suppressed write; rf_rd_o/rf_wdata_o hold last values when rf_we_o=0.
//  mem_rvalid_i in IDLE: ignored for writes; sets err_o (cleared only by reset).
//  instret_o increments by 1 in the cycle rf_we_o would pulse, including r0-suppressed retirements; wraps 2^CNT_W-1 -> 0.
//  ex_valid_i while ex_ready_o=0: not consumed; upstream holds inputs stable.
//  Reset asserted in WAIT_LOAD: load abandoned; a later mem_rvalid_i in IDLE sets err_o.
// TESTING
//  ALU: accept rd=5, data=0xDEADBEEF -> next cycle rf_we_o=1, rf_rd_o=5, rf_wdata_o=0xDEADBEEF; instret_o=1.
//  r0: accept rd=0, data=0x1234 -> rf_we_o stays 0; instret_o increments.
//  LB off=3, rdata=0x80FF_0011 after 3 wait cycles -> busy_o=1 for 4 cycles, ex_ready_o=0;
//   write r7=0xFFFF_FF80; LBU same -> 0x0000_0080; LH off=2 -> 0xFFFF_80FF.
//  Back-to-back: ALU, load, ALU with ex_valid_i held -> second ALU accepted only the cycle after mem_rvalid_i; writes in order.
//  Stray mem_rvalid_i in IDLE -> no write, err_o=1 and stays 1; reset low -> err_o=0.
//  Reset mid-WAIT_LOAD, then mem_rvalid_i -> no write, err_o=1. CNT_W=4: 16 retirements -> instret_o wraps to 0.

Source files
------------

// File: rtl/writeback.sv
// Writeback stage: retires ALU results immediately and load results after the
// memory response, producing one registered register-file write per instruction.
module writeback #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [RA_W-1:0]  ex_rd_i,
  input  logic [XLEN-1:0]  ex_data_i,
  input  logic             ex_is_load_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [1:0]       ex_addr_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             rf_we_o,
  output logic [RA_W-1:0]  rf_rd_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [RA_W-1:0]  r_ld_rd;
  logic [2:0]       r_ld_f3;
  logic [1:0]       r_ld_off;
  logic             r_we;
  logic [RA_W-1:0]  r_rd;
  logic [XLEN-1:0]  r_wdata;
  logic             r_err;
  logic [CNT_W-1:0] r_instret;

  logic             w_accept;
  logic             w_retire;
  logic [RA_W-1:0]  w_ret_rd;
  logic [XLEN-1:0]  w_ret_data;
  logic [XLEN-1:0]  w_load_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (ex_valid_i && ex_is_load_i) w_next = WAIT_LOAD;
      WAIT_LOAD: if (mem_rvalid_i)               w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ex_ready_o = (r_state == IDLE);
    busy_o     = (r_state == WAIT_LOAD);
  end

  assign w_accept = ex_valid_i & (r_state == IDLE);

  // Load data extraction; half-word selection ignores offset bit 0
  always_comb begin
    w_byte = mem_rdata_i[{r_ld_off, 3'b000} +: 8];
    w_half = mem_rdata_i[{r_ld_off[1], 4'b0000} +: 16];
    case (r_ld_f3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = XLEN'(w_byte);
      3'b101:  w_load_data = XLEN'(w_half);
      default: w_load_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    w_retire   = 1'b0;
    w_ret_rd   = ex_rd_i;
    w_ret_data = ex_data_i;
    if (r_state == IDLE) begin
      w_retire = w_accept & ~ex_is_load_i;
    end else if (mem_rvalid_i) begin
      w_retire   = 1'b1;
      w_ret_rd   = r_ld_rd;
      w_ret_data = w_load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_rd   <= '0;
      r_ld_f3   <= '0;
      r_ld_off  <= '0;
      r_we      <= 1'b0;
      r_rd      <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_accept && ex_is_load_i) begin
        r_ld_rd  <= ex_rd_i;
        r_ld_f3  <= ex_funct3_i;
        r_ld_off <= ex_addr_i;
      end
      r_we <= w_retire && (w_ret_rd != '0);
      // r0-suppressed retirements still count but leave the write port untouched
      if (w_retire && (w_ret_rd != '0)) begin
        r_rd    <= w_ret_rd;
        r_wdata <= w_ret_data;
      end
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
      if ((r_state == IDLE) && mem_rvalid_i) r_err <= 1'b1;
    end
  end

  assign rf_we_o    = r_we;
  assign rf_rd_o    = r_rd;
  assign rf_wdata_o = r_wdata;
  assign err_o      = r_err;
  assign instret_o  = r_instret;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic [31:0] ex_data_i = '0;
  logic        ex_is_load_i = 1'b0;
  logic [2:0]  ex_funct3_i = '0;
  logic [1:0]  ex_addr_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  logic        ex_ready_o, rf_we_o, busy_o, err_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o, instret_o;
  logic        ex_ready4, rf_we4, busy4, err4;
  logic [4:0]  rf_rd4;
  logic [31:0] rf_wdata4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i), .ex_is_load_i(ex_is_load_i),
    .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o),
    .rf_wdata_o(rf_wdata_o), .busy_o(busy_o), .err_o(err_o), .instret_o(instret_o)
  );

  writeback #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready4),
    .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i), .ex_is_load_i(ex_is_load_i),
    .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we4), .rf_rd_o(rf_rd4),
    .rf_wdata_o(rf_wdata4), .busy_o(busy4), .err_o(err4), .instret_o(instret4)
  );

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = ((off >= 2) ? (w >> 16) : w) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  logic        m_pend = 0, m_we = 0, m_err = 0, m_acc = 0;
  logic [4:0]  m_prd = 0, m_rd = 0;
  logic [2:0]  m_pf3 = 0;
  logic [1:0]  m_poff = 0;
  logic [31:0] m_wd = 0, m_cnt = 0;

  always @(posedge clk or negedge reset) begin : model
    logic        ret;
    logic [4:0]  rd;
    logic [31:0] d;
    if (!reset) begin
      m_pend <= 0; m_we <= 0; m_err <= 0; m_acc <= 0;
      m_prd <= 0; m_rd <= 0; m_pf3 <= 0; m_poff <= 0; m_wd <= 0; m_cnt <= 0;
    end else begin
      ret = 0; rd = ex_rd_i; d = ex_data_i;
      m_acc <= 0;
      if (!m_pend) begin
        if (mem_rvalid_i) m_err <= 1;
        if (ex_valid_i) begin
          m_acc <= 1;
          if (ex_is_load_i) begin
            m_pend <= 1; m_prd <= ex_rd_i; m_pf3 <= ex_funct3_i; m_poff <= ex_addr_i;
          end else ret = 1;
        end
      end else if (mem_rvalid_i) begin
        ret = 1; rd = m_prd; d = extract(m_pf3, m_poff, mem_rdata_i); m_pend <= 0;
      end
      m_we <= ret && (rd != 0);
      if (ret && rd != 0) begin m_rd <= rd; m_wd <= d; end
      if (ret) m_cnt <= m_cnt + 1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("ready",   32'(ex_ready_o), 32'(!m_pend));
      cmp("busy",    32'(busy_o),     32'(m_pend));
      cmp("we",      32'(rf_we_o),    32'(m_we));
      cmp("rd",      32'(rf_rd_o),    32'(m_rd));
      cmp("wdata",   rf_wdata_o,      m_wd);
      cmp("err",     32'(err_o),      32'(m_err));
      cmp("instret", instret_o,       m_cnt);
      cmp("instret4", 32'(instret4),  m_cnt & 32'hF);
      cmp("we4",     32'(rf_we4),     32'(m_we));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    ex_valid_i = 0; ex_is_load_i = 0; mem_rvalid_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #2 reset = 0;
    @(negedge clk);
    cmp("rst_we", 32'(rf_we_o), 0);
    cmp("rst_err", 32'(err_o), 0);
    cmp("rst_cnt", instret_o, 0);
    cmp("rst_busy", 32'(busy_o), 0);
    reset = 1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] data, input bit ld,
                       input logic [2:0] f3, input logic [1:0] off);
    @(negedge clk);
    ex_valid_i = 1; ex_rd_i = rd; ex_data_i = data; ex_is_load_i = ld;
    ex_funct3_i = f3; ex_addr_i = off; mem_rvalid_i = 0;
    @(negedge clk);
    ex_valid_i = 0;
  endtask

  // Load with a given number of empty wait cycles; returns observed busy cycles
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] w, input int waits, output int busy_n);
    issue(rd, 32'h0, 1, f3, off);
    busy_n = 0;
    for (int i = 0; i < waits; i++) begin
      if (busy_o) busy_n++;
      @(negedge clk);
    end
    if (busy_o) busy_n++;
    mem_rvalid_i = 1; mem_rdata_i = w;
    @(negedge clk);
    mem_rvalid_i = 0;
    if (busy_o) busy_n++;
  endtask

  initial begin
    int bn;
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    #1 reset = 0;
    @(negedge clk);
    reset = 1;
    chk_on = 1;
    cmp("init_ready", 32'(ex_ready_o), 1);

    issue(5'd5, 32'hDEADBEEF, 0, 3'd0, 2'd0);
    cmp("alu_we", 32'(rf_we_o), 1);
    cmp("alu_rd", 32'(rf_rd_o), 5);
    cmp("alu_data", rf_wdata_o, 32'hDEADBEEF);
    cmp("alu_cnt", instret_o, 1);

    issue(5'd0, 32'h1234, 0, 3'd0, 2'd0);
    cmp("r0_we", 32'(rf_we_o), 0);
    cmp("r0_cnt", instret_o, 2);
    cmp("r0_hold", rf_wdata_o, 32'hDEADBEEF);

    do_load(5'd7, 3'd0, 2'd3, 32'h80FF_0011, 3, bn);
    cmp("lb_busy_cycles", 32'(bn), 4);
    cmp("lb_we", 32'(rf_we_o), 1);
    cmp("lb_rd", 32'(rf_rd_o), 7);
    cmp("lb_data", rf_wdata_o, 32'hFFFF_FF80);
    do_load(5'd7, 3'd4, 2'd3, 32'h80FF_0011, 1, bn);
    cmp("lbu_data", rf_wdata_o, 32'h0000_0080);
    do_load(5'd7, 3'd1, 2'd2, 32'h80FF_0011, 0, bn);
    cmp("lh_data", rf_wdata_o, 32'hFFFF_80FF);
    cmp("model_pin", extract(3'd5, 2'd1, 32'h80FF_0011), 32'h0000_0011);

    // Back-to-back ALU, load, ALU with valid held
    @(negedge clk);
    ex_valid_i = 1; ex_rd_i = 1; ex_data_i = 32'h11; ex_is_load_i = 0;
    @(negedge clk);
    ex_rd_i = 2; ex_is_load_i = 1; ex_funct3_i = 3'd2;
    @(negedge clk);
    cmp("b2b_w1", 32'(rf_rd_o), 1);
    ex_rd_i = 3; ex_data_i = 32'h33; ex_is_load_i = 0;
    @(negedge clk);
    cmp("b2b_stall", 32'(ex_ready_o), 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid_i = 0;
    cmp("b2b_w2_rd", 32'(rf_rd_o), 2);
    cmp("b2b_w2_data", rf_wdata_o, 32'hCAFE_F00D);
    cmp("b2b_ready", 32'(ex_ready_o), 1);
    @(negedge clk);
    ex_valid_i = 0;
    cmp("b2b_w3_rd", 32'(rf_rd_o), 3);
    cmp("b2b_w3_data", rf_wdata_o, 32'h33);

    // Stray response in IDLE
    @(negedge clk);
    mem_rvalid_i = 1;
    @(negedge clk);
    mem_rvalid_i = 0;
    cmp("stray_we", 32'(rf_we_o), 0);
    cmp("stray_err", 32'(err_o), 1);
    repeat (3) @(negedge clk);
    cmp("err_sticky", 32'(err_o), 1);
    do_reset();

    // Reset while a load is outstanding
    issue(5'd9, 32'h0, 1, 3'd2, 2'd0);
    #2 reset = 0;
    @(negedge clk);
    reset = 1;
    mem_rvalid_i = 1;
    @(negedge clk);
    mem_rvalid_i = 0;
    cmp("abandon_we", 32'(rf_we_o), 0);
    cmp("abandon_err", 32'(err_o), 1);
    do_reset();

    // 16 retirements wrap the narrow counter
    @(negedge clk);
    ex_valid_i = 1; ex_is_load_i = 0;
    for (int i = 0; i < 16; i++) begin
      ex_rd_i = 5'(i); ex_data_i = 32'(i * 7);
      @(negedge clk);
    end
    ex_valid_i = 0;
    cmp("wrap4", 32'(instret4), 0);
    cmp("wrap32", instret_o, 16);

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 997 == 996) do_reset();
      @(negedge clk);
      if (!(ex_valid_i && !m_acc)) begin
        ex_valid_i   = ($urandom % 3) != 0;
        ex_rd_i      = 5'($urandom);
        ex_data_i    = $urandom;
        ex_is_load_i = 1'($urandom);
        ex_funct3_i  = f3s[$urandom % 8];
        ex_addr_i    = 2'($urandom);
      end
      if (mem_rvalid_i)  mem_rvalid_i = 0;
      else if (m_pend)   mem_rvalid_i = ($urandom % 3) == 0;
      else               mem_rvalid_i = ($urandom % 200) == 0;
      mem_rdata_i = $urandom;
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
